axis_packet_forwarder: RTL and testbench

Read-side counterpart of the packet snooper. It takes a filter-accepted packet from a packet buffer read port and transmits it as an AXI-Stream master, one word per beat. When the last beat is accepted downstream, it pulses fwd_done so the buffer can be released. It sits between the packet memory's forwarder port and the egress stream.

---
 rtl/axis_packet_forwarder.sv | 153 +++++++++++++++
 tb/tb_axis_packet_forwarder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_forwarder.sv
// axis_packet_forwarder: streams one buffered packet out as AXI-Stream, one buffer word per beat.
// Read data lands in a 2-entry skid FIFO whose head drives the stream outputs directly.
module axis_packet_forwarder #(
  parameter int SN_FWD_DATA_WIDTH = 64,
  parameter int SN_FWD_ADDR_WIDTH = 9,
  parameter int PLEN_WIDTH        = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           packet_avail,
  input  logic [PLEN_WIDTH-1:0]          byte_length,
  output logic                           fwd_rd_en,
  output logic [SN_FWD_ADDR_WIDTH-1:0]   fwd_rd_addr,
  input  logic [SN_FWD_DATA_WIDTH-1:0]   fwd_rd_data,
  output logic                           fwd_done,
  output logic [SN_FWD_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [SN_FWD_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready
);

  localparam int BYTES = SN_FWD_DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(BYTES);
  localparam int CW    = SN_FWD_ADDR_WIDTH + 1;
  localparam int LW    = PLEN_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  typedef struct packed {
    logic                         last;
    logic [BYTES-1:0]             keep;
    logic [SN_FWD_DATA_WIDTH-1:0] data;
  } beat_t;

  state_t                       state;
  logic [CW-1:0]                nwords;
  logic [CW-1:0]                rd_cnt;
  logic [SN_FWD_ADDR_WIDTH-1:0] addr;
  logic [BYTES-1:0]             last_keep;
  logic                         inflight;
  logic                         inflight_last;
  logic                         head_valid;
  logic                         spare_valid;
  beat_t                        head;
  beat_t                        spare;
  beat_t                        incoming;

  logic [LW-1:0]                words_raw;
  logic                         clamp;
  logic [CW-1:0]                nwords_next;
  logic [PLEN_WIDTH-1:0]        rem;
  logic [BYTES-1:0]             keep_next;
  logic                         pop;
  logic                         issue;
  logic [1:0]                   occ;

  // Length decode: word count rounded up and clamped to the buffer depth, plus last-beat keep.
  always_comb begin
    words_raw   = ({1'b0, byte_length} + LW'(BYTES - 1)) >> SHIFT;
    clamp       = words_raw > (LW'(1) << SN_FWD_ADDR_WIDTH);
    nwords_next = clamp ? (CW'(1) << SN_FWD_ADDR_WIDTH) : CW'(words_raw);
    rem         = byte_length & PLEN_WIDTH'(BYTES - 1);
    keep_next   = (rem == '0 || clamp) ? '1 : ~({BYTES{1'b1}} << rem);
  end

  // A read is allowed only if its returning word is guaranteed a FIFO slot; a beat leaving
  // this cycle frees one, which keeps the stream gap-free when the sink never stalls.
  always_comb begin
    pop           = head_valid & m_axis_tready;
    occ           = 2'(inflight) + 2'(head_valid) + 2'(spare_valid);
    issue         = (state == STREAM) && (rd_cnt < nwords) && ((occ < 2'd2) || pop);
    incoming.data = fwd_rd_data;
    incoming.last = inflight_last;
    incoming.keep = inflight_last ? last_keep : '1;
  end

  assign fwd_rd_en     = issue;
  assign fwd_rd_addr   = addr;
  assign m_axis_tvalid = head_valid;
  assign m_axis_tdata  = head.data;
  assign m_axis_tkeep  = head.keep;
  assign m_axis_tlast  = head.last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      nwords        <= '0;
      rd_cnt        <= '0;
      addr          <= '0;
      last_keep     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      head_valid    <= 1'b0;
      spare_valid   <= 1'b0;
      head          <= '0;
      spare         <= '0;
      fwd_done      <= 1'b0;
    end else begin
      fwd_done      <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue && (rd_cnt == nwords - CW'(1));
      unique case (state)
        IDLE: begin
          if (packet_avail) begin
            nwords    <= nwords_next;
            last_keep <= keep_next;
            rd_cnt    <= '0;
            addr      <= '0;
            if (nwords_next == '0) begin
              state    <= DONE;
              fwd_done <= 1'b1;
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          // The address stops at the final word rather than running one past it.
          if (issue) begin
            rd_cnt <= rd_cnt + CW'(1);
            if (rd_cnt + CW'(1) < nwords) addr <= addr + SN_FWD_ADDR_WIDTH'(1);
          end
          if (pop) begin
            if (spare_valid) begin
              head        <= spare;
              spare       <= incoming;
              spare_valid <= inflight;
            end else begin
              head       <= incoming;
              head_valid <= inflight;
            end
          end else if (!head_valid) begin
            head       <= incoming;
            head_valid <= inflight;
          end else if (inflight) begin
            spare       <= incoming;
            spare_valid <= 1'b1;
          end
          if (pop && head.last) begin
            state       <= DONE;
            fwd_done    <= 1'b1;
            head_valid  <= 1'b0;
            spare_valid <= 1'b0;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_packet_forwarder.sv
// Randomized bench for axis_packet_forwarder: a buffer model feeds random words and a
// length-derived expected beat list is compared against every accepted beat.
module tb_axis_packet_forwarder;

  localparam int DW    = 64;
  localparam int AW    = 9;
  localparam int PW    = 32;
  localparam int KW    = DW / 8;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          packet_avail = 1'b0;
  logic [PW-1:0] byte_length = '0;
  logic          fwd_rd_en;
  logic [AW-1:0] fwd_rd_addr;
  logic [DW-1:0] fwd_rd_data = '0;
  logic          fwd_done;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;

  logic [DW-1:0]      mem [DEPTH];
  beat_t              expQ[$];
  beat_t              monExp;
  logic [DW+KW+1:0]   prevBeat;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit active = 1'b0;
  bit readyRandom = 1'b0;
  bit firstValidSeen, prevStall;
  int expN, readsIssued, beatsAccepted, doneSeen, sampleCyc, lastHsCyc, expAddr;

  axis_packet_forwarder #(
    .SN_FWD_DATA_WIDTH(DW),
    .SN_FWD_ADDR_WIDTH(AW),
    .PLEN_WIDTH(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .packet_avail(packet_avail),
    .byte_length(byte_length),
    .fwd_rd_en(fwd_rd_en),
    .fwd_rd_addr(fwd_rd_addr),
    .fwd_rd_data(fwd_rd_data),
    .fwd_done(fwd_done),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Packet buffer: one-cycle read latency, garbage on cycles without a read.
  always @(posedge clk) fwd_rd_data <= fwd_rd_en ? mem[fwd_rd_addr] : {$urandom, $urandom};

  initial forever begin
    @(posedge clk);
    #1;
    m_axis_tready = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stream monitor: ordering, content, stability under stall, read addressing and FIFO bound.
  always @(negedge clk) begin
    if (rst) begin
      prevStall = 1'b0;
    end else if (!active) begin
      checkOutput("idle_quiet", {fwd_done, m_axis_tvalid, fwd_rd_en}, 3'b000);
      prevStall = 1'b0;
    end else begin
      if (fwd_rd_en) begin
        checkOutput("rd_addr", fwd_rd_addr, expAddr);
        expAddr++;
        readsIssued++;
        if (readsIssued == 1) checkOutput("first_rd_cyc", cyc, sampleCyc + 1);
        checkOutput("rd_within_len", readsIssued <= expN, 1'b1);
      end
      if (prevStall)
        checkOutput("stall_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, prevBeat);
      if (m_axis_tvalid && !firstValidSeen) begin
        firstValidSeen = 1'b1;
        checkOutput("first_valid_cyc", cyc, (expN == 0) ? -1 : sampleCyc + 3);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beatsAccepted++;
        if (expQ.size() == 0) begin
          checkOutput("extra_beat", 1'b1, 1'b0);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("tdata", m_axis_tdata, monExp.data);
          checkOutput("tkeep", m_axis_tkeep, monExp.keep);
          checkOutput("tlast", m_axis_tlast, monExp.last);
        end
        if (m_axis_tlast) lastHsCyc = cyc;
      end
      if (fwd_rd_en) checkOutput("fifo_bound", (readsIssued - beatsAccepted) <= 2, 1'b1);
      prevStall = m_axis_tvalid && !m_axis_tready;
      prevBeat  = {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      if (fwd_done) begin
        doneSeen++;
        checkOutput("done_cyc", cyc, (expN == 0) ? sampleCyc + 1 : lastHsCyc + 1);
      end
    end
  end

  task automatic applyStimulus(input int len, input bit randReady, input int abortBeat);
    int  n, rem, bound, waited;
    bit  clamped;
    beat_t b;
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
    n       = (len + KW - 1) / KW;
    clamped = n > DEPTH;
    if (clamped) n = DEPTH;
    rem = len % KW;
    expQ.delete();
    for (int i = 0; i < n; i++) begin
      b.data = mem[i];
      b.last = (i == n - 1);
      b.keep = (b.last && rem != 0 && !clamped) ? KW'((1 << rem) - 1) : {KW{1'b1}};
      expQ.push_back(b);
    end
    @(posedge clk);
    #1;
    expN = n; readsIssued = 0; beatsAccepted = 0; doneSeen = 0; expAddr = 0; lastHsCyc = 0;
    firstValidSeen = 1'b0; prevStall = 1'b0; readyRandom = randReady;
    sampleCyc = cyc;
    active = 1'b1;
    packet_avail = 1'b1;
    byte_length  = len;
    @(posedge clk);
    #1;
    byte_length = $urandom;
    bound  = 8 * n + 40;
    waited = 0;
    if (abortBeat > 0) begin
      while (beatsAccepted < abortBeat && waited < bound) begin
        @(negedge clk);
        #1;
        waited++;
      end
      checkOutput("abort_reached", waited < bound, 1'b1);
      rst = 1'b1;
      packet_avail = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      active = 1'b0;
      expQ.delete();
      @(negedge clk);
      checkOutput("rst_mid_tvalid", m_axis_tvalid, 1'b0);
      checkOutput("rst_mid_rd_en", fwd_rd_en, 1'b0);
      checkOutput("rst_mid_done", fwd_done, 1'b0);
      repeat (4) @(negedge clk);
    end else begin
      while (doneSeen == 0 && waited < bound) begin
        @(negedge clk);
        #1;
        waited++;
      end
      packet_avail = 1'b0;
      checkOutput("done_seen", doneSeen, 1);
      checkOutput("beats_total", beatsAccepted, n);
      checkOutput("exp_drained", expQ.size(), 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_tvalid", m_axis_tvalid, 1'b0);
    checkOutput("reset_tdata", m_axis_tdata, '0);
    checkOutput("reset_tkeep", m_axis_tkeep, '0);
    checkOutput("reset_tlast", m_axis_tlast, 1'b0);
    checkOutput("reset_rd_en", fwd_rd_en, 1'b0);
    checkOutput("reset_done", fwd_done, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    applyStimulus(20, 1'b0, 0);
    applyStimulus(16, 1'b0, 0);
    applyStimulus(0, 1'b0, 0);
    applyStimulus(64, 1'b1, 0);
    applyStimulus(9, 1'b0, 0);
    applyStimulus(8, 1'b0, 0);
    applyStimulus(40, 1'b0, 3);
    applyStimulus(8, 1'b0, 0);
    applyStimulus(4100, 1'b1, 0);
    for (int k = 0; k < 6; k++) applyStimulus(int'($urandom_range(1, 300)), 1'b1, 0);

    @(posedge clk);
    #1;
    active = 1'b0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
